alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one 64-bit base ALU between two requesters: req0 is the integer
//   issue pipe, req1 is the address/branch helper. Arbitration is round-robin.
//   Each requester uses a valid/ready handshake. Accepted operations go through
//   the combinational ALU into a one-entry registered response buffer that
//   honours backpressure. Sits between the issue stage and writeback.
// PARAMETERS
//   TAG_W   4   width of the requester tag returned with each result
//   PERF_W  32  width of each performance counter (ALU_ARB_PERF_EN only)
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   req0_valid   in   1      req0 operation valid
//   req0_ready   out  1      req0 operation accepted this cycle (when valid)
//   req0_op1     in   64     operand 1
//   req0_op2     in   64     operand 2 (shifts use [5:0])
//   req0_ctrl    in   4      ALU op: ADD0 SUB1 AND2 OR3 XOR4 NOT5 SLT6 SLTU7 SLL8 SRL9 SRA10
//   req0_tag     in   TAG_W  opaque tag, returned unchanged
//   req1_*       -    -      identical set for requester 1
//   rsp_valid    out  1      response buffer holds a result
//   rsp_ready    in   1      consumer takes the result this cycle
//   rsp_result   out  64     ALU result
//   rsp_id       out  1      source requester (0/1)
//   rsp_tag      out  TAG_W  tag of the originating request
// BEHAVIOUR
//   - can_issue = !rsp_valid | rsp_ready. The buffer accepts when empty or draining.
//   - Grant is computed from req*_valid and last_grant only, never from ready:
//     only one valid -> grant it; both valid -> grant !last_grant; none -> no grant.
//   - reqN_ready = grantN & can_issue. Transfer = reqN_valid & reqN_ready.
//     At most one transfer per cycle.
//   - On transfer at edge N: buffer loads base-ALU(op1,op2,ctrl) of the granted
//     request, plus rsp_id and rsp_tag. rsp_valid=1 after edge N.
//     Latency is 1 cycle. Throughput is 1 op/cycle while rsp_ready=1.
//   - last_grant updates to the transferring requester on transfer only.
//     Stalled grants do not rotate priority.
//   - Drain without transfer: rsp_valid->0 and rsp_* hold their last values.
//     Drain with transfer on the same edge: new result loaded, rsp_valid stays 1.
//   - While rsp_valid & !rsp_ready: all rsp_* outputs are stable.
//     Both reqN_ready=0.
//   - Requesters hold valid and payload stable until ready. The simulation-only
//     assertion fires on violation.
//   - ALU semantics: SLT signed compare, SLTU unsigned compare, SRA sign-fills.
//     Shift amount is op2[5:0]. Codes 11..15 yield 64'd0; the op is still
//     accepted and returned.
//   - Reset values: rsp_valid=0, rsp_result=0, rsp_id=0, rsp_tag=0,
//     last_grant=1 (req0 wins the first conflict), all perf counters=0.
//   - Reset mid-operation: a buffered result is discarded.
//     reqN_ready=0 during the rst cycle.
// CONFIGURATION
//   ALU_ARB_PERF_EN defined: adds outputs perf_grant0, perf_grant1,
//     perf_conflict, perf_stall, each [PERF_W-1:0], saturating at all-ones.
//     grantN counts transfers from reqN. conflict counts cycles with both valid.
//     stall counts cycles with rsp_valid & !rsp_ready. All clear on rst.
//   Undefined: these ports and counters do not exist. Functional behaviour
//     is identical either way.
// TESTING
//   1 Reset, then req0 ADD op1=5 op2=7 tag=3, rsp_ready=1
//     -> next cycle rsp_valid=1, result=12, id=0, tag=3.
//   2 Both valid every cycle, rsp_ready=1, req0 SUB 10-3, req1 SLT -1<1
//     -> grants alternate 0,1,0,1 and results alternate 7,1.
//   3 Buffer full with rsp_ready=0 for 3 cycles, both valid
//     -> both ready=0 and rsp_* stable. When rsp_ready rises, drain and accept
//     happen on the same edge and rsp_valid stays 1.
//   4 req1 SRA op1=64'h8000_0000_0000_0000 op2=63 -> all-ones.
//     SLL op2=64 (amt 0) -> op1 unchanged. ctrl=4'hF -> result 0, id=1.
//   5 rst asserted while rsp_valid=1 -> next cycle rsp_valid=0.
//     The first conflict after reset is granted to req0.
//   6 (ALU_ARB_PERF_EN) Run scenario 2 for 8 cycles
//     -> grant0=4, grant1=4, conflict=8, stall=0. With PERF_W=4 forced, the
//     counters saturate at 15.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle for alu_share_arbiter: two requester channels and one response channel.
// master = requesters plus result consumer, slave = the arbiter.
interface alu_share_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [63:0]      req0_op1;
    logic [63:0]      req0_op2;
    logic [3:0]       req0_ctrl;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [63:0]      req1_op1;
    logic [63:0]      req1_op2;
    logic [3:0]       req1_ctrl;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_result;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_ctrl, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2, req1_ctrl, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_result, rsp_id, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_ctrl, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2, req1_ctrl, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_result, rsp_id, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one 64-bit ALU between two valid/ready requesters, one-entry response buffer.
// Define ALU_ARB_PERF_EN to add saturating perf counters (perf_grant0/1, perf_conflict, perf_stall).
module alu_share_arbiter #(
    parameter int TAG_W = 4
`ifdef ALU_ARB_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic clk,
    input  logic rst,
    alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_grant0,
    output logic [PERF_W-1:0] perf_grant1,
    output logic [PERF_W-1:0] perf_conflict,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_op_e;

    logic             rsp_valid_q;
    logic [63:0]      rsp_result_q;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             last_grant;

    logic             can_issue;
    logic             grant0;
    logic             grant1;
    logic             xfer0;
    logic             xfer1;
    logic [63:0]      sel_op1;
    logic [63:0]      sel_op2;
    logic [3:0]       sel_ctrl;
    logic [TAG_W-1:0] sel_tag;
    logic [5:0]       shamt;
    logic [63:0]      alu_result;

    // Grant depends only on valids and last_grant so it never waits on ready.
    assign can_issue = !rsp_valid_q || bus.rsp_ready;
    assign grant0    = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign xfer0     = grant0 && can_issue && !rst;
    assign xfer1     = grant1 && can_issue && !rst;

    assign bus.req0_ready = xfer0;
    assign bus.req1_ready = xfer1;

    assign sel_op1  = grant1 ? bus.req1_op1  : bus.req0_op1;
    assign sel_op2  = grant1 ? bus.req1_op2  : bus.req0_op2;
    assign sel_ctrl = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
    assign sel_tag  = grant1 ? bus.req1_tag  : bus.req0_tag;
    assign shamt    = sel_op2[5:0];

    always_comb begin
        // NOTE: default assigned first so every path drives alu_result and no latch is inferred.
        alu_result = '0;
        case (sel_ctrl)
            ALU_ADD:  alu_result = sel_op1 + sel_op2;
            ALU_SUB:  alu_result = sel_op1 - sel_op2;
            ALU_AND:  alu_result = sel_op1 & sel_op2;
            ALU_OR:   alu_result = sel_op1 | sel_op2;
            ALU_XOR:  alu_result = sel_op1 ^ sel_op2;
            ALU_NOT:  alu_result = ~sel_op1;
            ALU_SLT:  alu_result = {63'd0, $signed(sel_op1) < $signed(sel_op2)};
            ALU_SLTU: alu_result = {63'd0, sel_op1 < sel_op2};
            ALU_SLL:  alu_result = sel_op1 << shamt;
            ALU_SRL:  alu_result = sel_op1 >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(sel_op1) >>> shamt);
            default:  alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            last_grant   <= 1'b1;
        end else if (xfer0 || xfer1) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= alu_result;
            rsp_id_q     <= xfer1;
            rsp_tag_q    <= sel_tag;
            last_grant   <= xfer1;
        end else if (bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;

`ifdef ALU_ARB_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
            perf_stall    <= '0;
        end else begin
            if (xfer0)                             perf_grant0   <= sat_inc(perf_grant0);
            if (xfer1)                             perf_grant1   <= sat_inc(perf_grant1);
            if (bus.req0_valid && bus.req1_valid)  perf_conflict <= sat_inc(perf_conflict);
            if (rsp_valid_q && !bus.rsp_ready)     perf_stall    <= sat_inc(perf_stall);
        end
    end
`endif

`ifndef SYNTHESIS
    // A stalled requester must keep valid and its payload unchanged until accepted.
    req0_hold_a: assert property (@(posedge clk) disable iff (rst)
        (bus.req0_valid && !bus.req0_ready) |=> (bus.req0_valid &&
        $stable({bus.req0_op1, bus.req0_op2, bus.req0_ctrl, bus.req0_tag})));
    req1_hold_a: assert property (@(posedge clk) disable iff (rst)
        (bus.req1_valid && !bus.req1_ready) |=> (bus.req1_valid &&
        $stable({bus.req1_op1, bus.req1_op2, bus.req1_ctrl, bus.req1_tag})));
`endif

endmodule
